// File: rtl/sm_rf_write_arbiter_if.sv
// Write-back request bus between the CPU write-back sources and the
// register-file write arbiter, plus the registered write-port outputs.
interface sm_rf_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int IDW  = 3
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_addr;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [4:0]           rf_a;
    logic [31:0]          rf_wd;
    logic [IDW-1:0]       grant_id;
    logic                 x0_drop;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, rf_we, rf_a, rf_wd, grant_id, x0_drop
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, rf_we, rf_a, rf_wd, grant_id, x0_drop
    );
endinterface

// File: rtl/sm_rf_write_arbiter.sv
// Shares the register file write port among NREQ requesters, round-robin by default.
// Define SM_RF_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins).
module sm_rf_write_arbiter #(
    parameter int NREQ = 3,
    parameter int IDW  = 3
) (
    input logic                  clk,
    input logic                  rst,
    sm_rf_write_arbiter_if.slave bus
);
    logic [IDW-1:0]  scan_base;
    logic            acc;
    logic [IDW-1:0]  gidx;
    logic [NREQ-1:0] ready;
    logic [4:0]      sel_addr;
    logic [31:0]     sel_data;

    logic            we_q;
    logic            drop_q;
    logic [4:0]      a_q;
    logic [31:0]     wd_q;
    logic [IDW-1:0]  gid_q;

`ifdef SM_RF_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [IDW-1:0] ptr;

    assign scan_base = ptr;

    // Winner drops to lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (acc) begin
            ptr <= (32'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
        end
    end
`endif

    always_comb begin
        int unsigned     idx;
        logic [NREQ-1:0] vrot;
        acc   = 1'b0;
        gidx  = '0;
        idx   = 0;
        vrot  = '0;
        if (!rst && !bus.hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx  = (32'(scan_base) + k) % NREQ;
                vrot = bus.req_valid >> idx;
                if (!acc && vrot[0]) begin
                    acc  = 1'b1;
                    gidx = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        logic [NREQ*5-1:0]  addr_sh;
        logic [NREQ*32-1:0] data_sh;
        ready    = acc ? (NREQ'(1) << gidx) : '0;
        addr_sh  = bus.req_addr >> (5 * gidx);
        data_sh  = bus.req_data >> (32 * gidx);
        sel_addr = addr_sh[4:0];
        sel_data = data_sh[31:0];
    end

    // x0 writes still update address/data so the dropped beat is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            drop_q <= 1'b0;
            a_q    <= '0;
            wd_q   <= '0;
            gid_q  <= '0;
        end else begin
            we_q   <= 1'b0;
            drop_q <= 1'b0;
            if (acc) begin
                a_q   <= sel_addr;
                wd_q  <= sel_data;
                gid_q <= gidx;
                if (sel_addr != 5'd0) begin
                    we_q <= 1'b1;
                end else begin
                    drop_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rf_we     = we_q;
    assign bus.rf_a      = a_q;
    assign bus.rf_wd     = wd_q;
    assign bus.grant_id  = gid_q;
    assign bus.x0_drop   = drop_q;
endmodule

// File: tb/tb_sm_rf_write_arbiter.sv
// Randomized self-checking bench for sm_rf_write_arbiter against a behavioural model.
// Honours SM_RF_ARB_FIXED_PRIO_EN in the model when the design is built with it.
module tb_sm_rf_write_arbiter;
    localparam int NREQ = 3;
    localparam int IDW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0]  ta [NREQ];
    logic [31:0] td [NREQ];
    logic [31:0] mem [32];

    int checks   = 0;
    int failures = 0;

    int             m_ptr;
    logic           m_we;
    logic [4:0]     m_a;
    logic [31:0]    m_wd;
    logic [IDW-1:0] m_gid;
    logic           m_drop;

    sm_rf_write_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    sm_rf_write_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.req_addr = '0;
        bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*5 +: 5]   = ta[i];
            bus.req_data[i*32 +: 32] = td[i];
        end
    end

    // Register file mirror: commits the registered write on the next edge.
    always @(posedge clk) begin
        if (bus.rf_we) mem[bus.rf_a] <= bus.rf_wd;
    end

    function automatic int model_grant(input logic [NREQ-1:0] v, input logic h, input int p);
        if (h || v == '0) return -1;
`ifdef SM_RF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_a = '0; m_wd = '0; m_gid = '0; m_drop = 0;
    endtask

    task automatic model_clock(input int g);
        m_we = 0;
        m_drop = 0;
        if (g >= 0) begin
            m_a   = ta[g];
            m_wd  = td[g];
            m_gid = IDW'(g);
            if (ta[g] != 0) m_we = 1; else m_drop = 1;
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int g;
        bus.hold = 0;
        bus.req_valid = 3'b111;
        ta[0] = 5; ta[1] = 6; ta[2] = 7;
        td[0] = 32'hA; td[1] = 32'hB; td[2] = 32'hC;
        model_reset();
        @(negedge clk);
        checks++;
        if ({bus.rf_we, bus.rf_a, bus.rf_wd, bus.grant_id, bus.x0_drop} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {bus.rf_we, bus.rf_a, bus.rf_wd, bus.grant_id, bus.x0_drop});
        end
        checks++;
        if (bus.req_ready !== '0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=000", bus.req_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        g = model_grant(bus.req_valid, bus.hold, m_ptr);
        checks++;
        if (bus.req_ready !== 3'b001 || onehot(g) !== 3'b001) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=001", bus.req_ready);
        end
        model_clock(g);
        tick();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_a !== 5'd5 || bus.rf_wd !== 32'hA) begin
            failures++;
            $display("FAIL reset_first_write got=%b/%0d/%h exp=1/5/a", bus.rf_we, bus.rf_a, bus.rf_wd);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_a !== 5'd0 || bus.grant_id !== '0 || bus.req_ready !== '0) begin
            failures++;
            $display("FAIL reset_async got we=%b a=%0d gid=%0d rdy=%b exp 0/0/0/000",
                     bus.rf_we, bus.rf_a, bus.grant_id, bus.req_ready);
        end
        model_reset();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 3'b001) begin
            failures++;
            $display("FAIL reset_ptr_cleared got=%b exp=001", bus.req_ready);
        end
    endtask

    task automatic test_round_robin();
        int g;
        reset_pulse();
        bus.hold = 0;
        bus.req_valid = 3'b111;
        ta[0] = 5; ta[1] = 6; ta[2] = 7;
        td[0] = 32'hA; td[1] = 32'hB; td[2] = 32'hC;
        for (int c = 0; c < 7; c++) begin
            #1;
            g = model_grant(bus.req_valid, bus.hold, m_ptr);
            checks++;
            if (bus.req_ready !== onehot(g)) begin
                failures++;
                $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, onehot(g));
            end
            model_clock(g);
            tick();
            checks++;
            if ({bus.rf_we, bus.rf_a, bus.rf_wd, bus.grant_id, bus.x0_drop} !== {m_we, m_a, m_wd, m_gid, m_drop}) begin
                failures++;
                $display("FAIL rr_out cyc=%0d got=%h exp=%h", c,
                         {bus.rf_we, bus.rf_a, bus.rf_wd, bus.grant_id, bus.x0_drop}, {m_we, m_a, m_wd, m_gid, m_drop});
            end
        end
    endtask

    task automatic test_x0_drop();
        int g;
        reset_pulse();
        bus.hold = 0;
        ta[0] = 5; ta[1] = 0; ta[2] = 7;
        td[1] = 32'hDEADBEEF;
        bus.req_valid = 3'b010;
        #1;
        g = model_grant(bus.req_valid, bus.hold, m_ptr);
        checks++;
        if (bus.req_ready !== 3'b010) begin
            failures++;
            $display("FAIL x0_ready got=%b exp=010", bus.req_ready);
        end
        model_clock(g);
        tick();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.x0_drop !== 1'b1 || bus.grant_id !== 3'd1 || bus.rf_wd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL x0_out got we=%b drop=%b gid=%0d wd=%h exp 0/1/1/deadbeef",
                     bus.rf_we, bus.x0_drop, bus.grant_id, bus.rf_wd);
        end
        ta[1] = 6;
        bus.req_valid = 3'b111;
        #1;
        g = model_grant(bus.req_valid, bus.hold, m_ptr);
        checks++;
        if (bus.req_ready !== onehot(g)) begin
            failures++;
            $display("FAIL x0_next_ptr got=%b exp=%b", bus.req_ready, onehot(g));
        end
        model_clock(g);
        tick();
        checks++;
        if (bus.x0_drop !== 1'b0 || bus.rf_we !== 1'b1) begin
            failures++;
            $display("FAIL x0_pulse_width got drop=%b we=%b exp 0/1", bus.x0_drop, bus.rf_we);
        end
    endtask

    task automatic test_hold();
        int g;
        reset_pulse();
        bus.req_valid = 3'b010;
        bus.hold = 1;
        ta[1] = 12; td[1] = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== '0) begin
                failures++;
                $display("FAIL hold_ready cyc=%0d got=%b exp=000", c, bus.req_ready);
            end
            model_clock(-1);
            tick();
            checks++;
            if (bus.rf_we !== 1'b0 || bus.rf_a !== m_a || bus.grant_id !== m_gid) begin
                failures++;
                $display("FAIL hold_out cyc=%0d got we=%b a=%0d exp 0/%0d", c, bus.rf_we, bus.rf_a, m_a);
            end
        end
        bus.hold = 0;
        #1;
        g = model_grant(bus.req_valid, bus.hold, m_ptr);
        checks++;
        if (bus.req_ready !== 3'b010) begin
            failures++;
            $display("FAIL hold_release got=%b exp=010", bus.req_ready);
        end
        model_clock(g);
        tick();
        bus.req_valid = '0;
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_a !== 5'd12 || bus.grant_id !== 3'd1) begin
            failures++;
            $display("FAIL hold_write got we=%b a=%0d gid=%0d exp 1/12/1", bus.rf_we, bus.rf_a, bus.grant_id);
        end
    endtask

    task automatic test_same_addr();
        int g;
        reset_pulse();
        bus.hold = 0;
        ta[0] = 9; td[0] = 32'h1;
        ta[1] = 3; td[1] = 32'h33;
        ta[2] = 9; td[2] = 32'h2;
        bus.req_valid = 3'b101;
        for (int c = 0; c < 2; c++) begin
            #1;
            g = model_grant(bus.req_valid, bus.hold, m_ptr);
            checks++;
            if (bus.req_ready !== onehot(g)) begin
                failures++;
                $display("FAIL same_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, onehot(g));
            end
            model_clock(g);
            tick();
            if (g >= 0) bus.req_valid[g] = 1'b0;
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_a !== 5'd9 || bus.rf_wd !== ((c == 0) ? 32'h1 : 32'h2)) begin
                failures++;
                $display("FAIL same_order cyc=%0d got we=%b a=%0d wd=%h exp 1/9/%0d", c,
                         bus.rf_we, bus.rf_a, bus.rf_wd, c + 1);
            end
        end
        tick();
        checks++;
        if (mem[9] !== 32'h2) begin
            failures++;
            $display("FAIL same_readback got=%h exp=2", mem[9]);
        end
        model_clock(-1);
    endtask

    task automatic test_random();
        int g;
        int wait_cnt [NREQ];
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        reset_pulse();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i] = ($urandom_range(0, 3) != 0);
                ta[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                td[i] = $urandom;
            end
            bus.hold = ($urandom_range(0, 7) == 0);
            #1;
            g = model_grant(bus.req_valid, bus.hold, m_ptr);
            checks++;
            if (bus.req_ready !== onehot(g)) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, onehot(g));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || bus.req_ready[i]) wait_cnt[i] = 0;
                else if (bus.req_ready != '0) wait_cnt[i]++;
            end
`ifndef SM_RF_ARB_FIXED_PRIO_EN
            for (int i = 0; i < NREQ; i++) begin
                checks++;
                if (wait_cnt[i] > NREQ - 1) begin
                    failures++;
                    $display("FAIL rand_fairness cyc=%0d req=%0d waited=%0d max=%0d", c, i, wait_cnt[i], NREQ - 1);
                end
            end
`endif
            model_clock(g);
            tick();
            checks++;
            if ({bus.rf_we, bus.rf_a, bus.rf_wd, bus.grant_id, bus.x0_drop} !== {m_we, m_a, m_wd, m_gid, m_drop}) begin
                failures++;
                $display("FAIL rand_out cyc=%0d got=%h exp=%h", c,
                         {bus.rf_we, bus.rf_a, bus.rf_wd, bus.grant_id, bus.x0_drop}, {m_we, m_a, m_wd, m_gid, m_drop});
            end
        end
        bus.req_valid = '0;
        bus.hold = 0;
    endtask

`ifdef SM_RF_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        int grants1;
        grants1 = 0;
        reset_pulse();
        bus.hold = 0;
        ta[0] = 4; ta[1] = 8;
        bus.req_valid = 3'b011;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.req_ready[1]) grants1++;
            checks++;
            if (bus.req_ready !== 3'b001) begin
                failures++;
                $display("FAIL fixed_ready cyc=%0d got=%b exp=001", c, bus.req_ready);
            end
            tick();
        end
        checks++;
        if (grants1 != 0) begin
            failures++;
            $display("FAIL fixed_starve got=%0d grants to req1 exp=0", grants1);
        end
        bus.req_valid = '0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = '0;
            td[i] = '0;
        end
        bus.hold = 0;
        bus.req_valid = '0;
        test_reset();
        test_round_robin();
        test_x0_drop();
        test_hold();
        test_same_addr();
`ifdef SM_RF_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
